// File: rtl/intpol2_d4_out_fifo.sv
// Output FIFO between the intpol2_D4 interpolator and the stream consumer.
// Ports: clk/rstn, clear flush, Write_Enable/data_in push side,
// m_valid/m_data/m_ready master port, Afull/Full/level/max_level/overflow.
module intpol2_d4_out_fifo #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 16,
  parameter int AF_MARGIN = 4
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       clear,
  input  logic                       Write_Enable,
  input  logic [DATA_W-1:0]          data_in,
  output logic                       Afull,
  output logic                       Full,
  output logic                       m_valid,
  output logic [DATA_W-1:0]          m_data,
  input  logic                       m_ready,
  output logic [$clog2(DEPTH):0]     level,
  output logic [$clog2(DEPTH):0]     max_level,
  output logic                       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wp;
  logic [AW-1:0]     r_rp;
  logic [LW-1:0]     r_level;
  logic [LW-1:0]     r_max;
  logic              r_ovf;

  logic              w_full;
  logic              w_pop;
  logic              w_push;
  logic              w_drop;
  logic [LW-1:0]     w_level_nxt;

  // Flags come from the registered level only.
  assign w_full = (r_level == LW'(DEPTH));
  assign w_pop  = (r_level != '0) && m_ready;
  // A full buffer still takes a write when the head leaves this cycle.
  assign w_push = Write_Enable && (!w_full || w_pop);
  assign w_drop = Write_Enable && w_full && !w_pop;

  always_comb begin
    w_level_nxt = r_level;
    unique case ({w_push, w_pop})
      2'b10:   w_level_nxt = r_level + LW'(1);
      2'b01:   w_level_nxt = r_level - LW'(1);
      default: w_level_nxt = r_level;
    endcase
  end

  // Storage is not flushed by clear; a write in a clear cycle is dropped.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++)
        r_mem[i] <= '0;
    end else if (w_push && !clear) begin
      r_mem[r_wp] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_level <= '0;
      r_max   <= '0;
      r_ovf   <= 1'b0;
    end else if (clear) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_level <= '0;
      r_max   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push)
        r_wp <= r_wp + AW'(1);
      if (w_pop)
        r_rp <= r_rp + AW'(1);
      r_level <= w_level_nxt;
      if (w_level_nxt > r_max)
        r_max <= w_level_nxt;
      if (w_drop)
        r_ovf <= 1'b1;
    end
  end

  assign m_valid   = (r_level != '0);
  assign m_data    = r_mem[r_rp];
  assign Full      = w_full;
  assign Afull     = (r_level >= LW'(DEPTH - AF_MARGIN));
  assign level     = r_level;
  assign max_level = r_max;
  assign overflow  = r_ovf;

endmodule

// File: tb/tb_intpol2_d4_out_fifo.sv
// Bench for intpol2_d4_out_fifo: queue scoreboard, directed steps.
// Inputs change on the falling edge, outputs checked on the falling edge.
module tb_intpol2_d4_out_fifo;

  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int AFM   = 4;
  localparam int LW    = 5;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          clear = 1'b0;
  logic          we = 1'b0;
  logic          rdy = 1'b0;
  logic [DW-1:0] din = '0;
  logic          Afull;
  logic          Full;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic [LW-1:0] level;
  logic [LW-1:0] max_level;
  logic          overflow;

  intpol2_d4_out_fifo #(
    .DATA_W(DW), .DEPTH(DEPTH), .AF_MARGIN(AFM)
  ) dut (
    .clk(clk), .rstn(rstn), .clear(clear),
    .Write_Enable(we), .data_in(din),
    .Afull(Afull), .Full(Full),
    .m_valid(m_valid), .m_data(m_data), .m_ready(rdy),
    .level(level), .max_level(max_level),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int            n_cmp = 0;
  int            n_mis = 0;
  logic [DW-1:0] q[$];
  bit            m_ovf = 1'b0;
  int            m_max = 0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state();
    chk("level", 64'(level), 64'(q.size()));
    chk("m_valid", 64'(m_valid), 64'(q.size() != 0));
    chk("Full", 64'(Full), 64'(q.size() == DEPTH));
    chk("Afull", 64'(Afull), 64'(q.size() >= DEPTH - AFM));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("max_level", 64'(max_level), 64'(m_max));
    if (q.size() != 0)
      chk("m_data", 64'(m_data), 64'(q[0]));
  endtask

  task automatic step(input bit w, input logic [DW-1:0] d,
                      input bit r, input bit c);
    bit            pop;
    bit            push;
    bit            full;
    logic [DW-1:0] e;
    we    = w;
    din   = d;
    rdy   = r;
    clear = c;
    full = (q.size() == DEPTH);
    pop  = (q.size() != 0) && r;
    push = w && (!full || pop);
    if (c) begin
      q.delete();
      m_ovf = 1'b0;
      m_max = 0;
    end else begin
      if (pop) begin
        e = q.pop_front();
        chk("pop_data", 64'(m_data), 64'(e));
      end
      if (push)
        q.push_back(d);
      if (w && full && !pop)
        m_ovf = 1'b1;
      if (q.size() > m_max)
        m_max = q.size();
    end
    @(posedge clk);
    @(negedge clk);
    we    = 1'b0;
    rdy   = 1'b0;
    clear = 1'b0;
    chk_state();
  endtask

  initial begin
    // reset / idle
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    chk_state();
    chk("rst_m_data", 64'(m_data), 64'd0);
    rstn = 1'b1;
    repeat (5) step(0, '0, 0, 0);

    // fill, overflow, drain
    for (int i = 1; i <= 16; i++)
      step(1, DW'(i), 0, 0);
    step(1, 32'h77, 0, 0);
    for (int i = 0; i < 16; i++)
      step(0, '0, 1, 0);

    // push and pop together at full
    step(0, '0, 0, 1);
    for (int i = 1; i <= 16; i++)
      step(1, DW'(32'h200 + i), 0, 0);
    step(1, 32'hAA, 1, 0);
    for (int i = 0; i < 16; i++)
      step(0, '0, 1, 0);

    // pointer wrap with streaming
    step(0, '0, 0, 1);
    for (int i = 0; i < 40; i++)
      step(1, DW'(32'h1000 + i), 1, 0);
    step(0, '0, 1, 0);

    // backpressure hold
    step(0, '0, 0, 1);
    step(1, 32'h55, 0, 0);
    step(1, 32'h66, 0, 0);
    repeat (3) step(0, '0, 0, 0);
    step(0, '0, 1, 0);
    step(0, '0, 1, 0);

    // clear priority at level 5 with overflow set
    step(0, '0, 0, 1);
    for (int i = 0; i < 16; i++)
      step(1, DW'(32'h300 + i), 0, 0);
    step(1, 32'h399, 0, 0);
    for (int i = 0; i < 11; i++)
      step(0, '0, 1, 0);
    chk("pre_clr_level", 64'(level), 64'd5);
    chk("pre_clr_ovf", 64'(overflow), 64'd1);
    step(1, 32'hDEAD, 1, 1);
    // rp is back at 0, so the head slot shows whether the write landed
    chk("clr_no_store", 64'(m_data), 64'h300);
    step(0, '0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_mis);
    $finish;
  end

endmodule
